// File: rtl/gpio_uart_rx.sv
// rtl/gpio_uart_rx.sv - 8N1 serial receiver for a GPIO pin with valid/ack byte handoff
//
// Purpose:
//   Receives 8N1 frames on an asynchronous GPIO line. Each byte is sampled at
//   the middle of its bit and then held for a consumer using a valid/ack
//   handshake. Bad stop bits and lost bytes are flagged.
//
// Ports:
//   CLOCK_50     in   single clock; all logic runs on its rising edge
//   RESET_N      in   asynchronous active-low reset
//   RX           in   serial line, asynchronous, idles high
//   RX_DATA      out  [7:0] last accepted byte
//   RX_VALID     out  RX_DATA holds a byte the consumer has not taken
//   RX_ACK       in   consumer takes the byte (ignored while RX_VALID is low)
//   RX_FRAME_ERR out  one-cycle pulse when a stop bit samples low
//   RX_OVERRUN   out  sticky: a byte was dropped because the previous one was not taken
//   RX_BUSY      out  receiver is in any state other than idle

module gpio_uart_rx #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       RX,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic       RX_ACK,
  output logic       RX_FRAME_ERR,
  output logic       RX_OVERRUN,
  output logic       RX_BUSY
);

  localparam int BIT_CYC  = CLK_HZ / BAUD;
  localparam int HALF_CYC = BIT_CYC / 2;
  // Counter only ever needs to reach BIT_CYC-1.
  localparam int CW       = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          rx_meta;
  logic          rx_s;
  logic          commit;
  logic          frame_err;
  logic          busy;

  // Two-flop synchronizer; resets to the idle (high) line level so a reset
  // never looks like a start bit.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
    end
  end

  // Frame FSM. The IDLE cycle that sees the falling edge counts as the first
  // cycle of the half bit, so START is entered with the counter already at 1.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      commit    <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      commit    <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            cnt   <= CNT_ONE;
            state <= S_START;
            busy  <= 1'b1;
          end
        end

        S_START: begin
          // >= keeps very small HALF_CYC values from wrapping past the compare.
          if (cnt >= HALF_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              bit_idx <= '0;
              state   <= S_DATA;
            end else begin
              // Line went back high: treat as a glitch, no output activity.
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        S_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            // LSB arrives first, so shifting right leaves it in bit 0.
            shreg <= {rx_s, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        S_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              commit <= 1'b1;
              state  <= S_IDLE;
              busy   <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        S_BREAK: begin
          // Wait out a held-low line so it is not taken as a new start bit.
          if (rx_s) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Consumer handoff. commit arrives one edge after the stop sample, while
  // shreg is still intact (it only shifts in DATA).
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      RX_DATA    <= 8'h00;
      RX_VALID   <= 1'b0;
      RX_OVERRUN <= 1'b0;
    end else begin
      if (commit) begin
        if (!RX_VALID || RX_ACK) begin
          // Free slot, or the pending byte is taken in this very cycle.
          RX_DATA  <= shreg;
          RX_VALID <= 1'b1;
        end else begin
          // Old byte still pending: keep it, lose the new one.
          RX_OVERRUN <= 1'b1;
        end
      end else if (RX_ACK && RX_VALID) begin
        RX_VALID <= 1'b0;
      end
    end
  end

  assign RX_FRAME_ERR = frame_err;
  assign RX_BUSY      = busy;

endmodule

// File: tb/tb_gpio_uart_rx.sv
// tb/tb_gpio_uart_rx.sv - scoreboard bench for gpio_uart_rx
module tb_gpio_uart_rx;

  localparam int CLK_HZ = 50000000;
  localparam int BAUD   = 115200;
  localparam int BIT    = CLK_HZ / BAUD;
  localparam int HALF   = BIT / 2;
  localparam int LAT    = 2 + HALF + 9 * BIT + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_busy;

  int n_cmp = 0;
  int n_bad = 0;
  int fe_cnt = 0;

  // Reference model state: bytes expected to appear, plus handshake flags.
  logic [7:0] exp_q[$];
  bit         mdl_pending = 0;
  bit         mdl_ovr = 0;

  logic       prev_v = 1'b0;
  logic [7:0] prev_d = 8'h00;

  gpio_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .CLOCK_50    (clk),
    .RESET_N     (rst_n),
    .RX          (rx),
    .RX_DATA     (rx_data),
    .RX_VALID    (rx_valid),
    .RX_ACK      (ack),
    .RX_FRAME_ERR(rx_frame_err),
    .RX_OVERRUN  (rx_overrun),
    .RX_BUSY     (rx_busy)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called #1 after an edge; returns #1 after the edge ending the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(BIT);
    end
    rx = stop_bit;
    cyc(BIT);
  endtask

  // Model of a good frame arriving with no acknowledge during its commit.
  task automatic model_frame(input logic [7:0] b);
    if (mdl_pending) mdl_ovr = 1;
    else begin
      exp_q.push_back(b);
      mdl_pending = 1;
    end
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    mdl_pending = 0;
  endtask

  // Monitor: every new byte presented on RX_DATA is checked against the queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (rx_valid && (!prev_v || rx_data != prev_d)) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL rx_data unexpected byte: got %02h, expected none", rx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (rx_data !== e) begin
            n_bad++;
            $display("FAIL rx_data: got %02h, expected %02h", rx_data, e);
          end
        end
      end
      if (rx_frame_err) fe_cnt++;
      prev_v = rx_valid;
      prev_d = rx_data;
    end
  end

  initial begin
    #(20 * 150000);
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    int fe0;
    logic [7:0] rb;

    // Reset state
    cyc(3);
    chk("reset rx_data", rx_data, 0);
    chk("reset rx_valid", rx_valid, 0);
    chk("reset rx_frame_err", rx_frame_err, 0);
    chk("reset rx_overrun", rx_overrun, 0);
    chk("reset rx_busy", rx_busy, 0);
    rst_n = 1'b1;
    cyc(5);

    // Single byte latency
    lat = 0;
    fork
      begin
        model_frame(8'h55);
        send_frame(8'h55, 1'b1);
      end
      begin
        while (lat < 6000) begin
          @(posedge clk);
          lat++;
          @(negedge clk);
          if (rx_valid) break;
        end
      end
    join
    chk("latency 0x55", lat, LAT);
    chk("no frame err 0x55", fe_cnt, 0);
    chk("valid after 0x55", rx_valid, 1);
    ack_pulse();
    chk("valid cleared by ack", rx_valid, 0);
    cyc(10);

    // Back-to-back, no ack: overrun
    model_frame(8'hA3);
    send_frame(8'hA3, 1'b1);
    model_frame(8'h0F);
    send_frame(8'h0F, 1'b1);
    chk("overrun data kept", rx_data, 8'hA3);
    chk("overrun flag", rx_overrun, mdl_ovr);
    ack_pulse();
    chk("valid cleared after overrun ack", rx_valid, 0);
    cyc(10);

    // Bad stop bit then break
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    cyc(BIT);
    chk("busy in break", rx_busy, 1);
    chk("one frame err pulse", fe_cnt - fe0, 1);
    chk("no valid after frame err", rx_valid, 0);
    rx = 1'b1;
    cyc(5);
    chk("busy released after break", rx_busy, 0);
    model_frame(8'h81);
    send_frame(8'h81, 1'b1);
    ack_pulse();
    cyc(10);

    // Glitch on idle line
    fe0 = fe_cnt;
    rx = 1'b0;
    cyc(50);
    chk("busy during glitch", rx_busy, 1);
    cyc(50);
    rx = 1'b1;
    cyc(400);
    chk("idle after glitch", rx_busy, 0);
    chk("no valid after glitch", rx_valid, 0);
    chk("no frame err after glitch", fe_cnt - fe0, 0);

    // Reset mid-frame
    fork
      send_frame(8'hFF, 1'b1);
      begin
        cyc(5 * BIT + 200);
        rst_n = 1'b0;
        #2;
        chk("midreset rx_data", rx_data, 0);
        chk("midreset rx_valid", rx_valid, 0);
        chk("midreset rx_frame_err", rx_frame_err, 0);
        chk("midreset rx_overrun", rx_overrun, 0);
        chk("midreset rx_busy", rx_busy, 0);
        mdl_pending = 0;
        mdl_ovr = 0;
        cyc(2);
        rst_n = 1'b1;
      end
    join
    cyc(20);
    chk("no byte from aborted frame", rx_valid, 0);
    model_frame(8'h12);
    send_frame(8'h12, 1'b1);
    chk("valid after 0x12", rx_valid, 1);
    ack_pulse();
    cyc(10);

    // Ack coincident with commit
    model_frame(8'h11);
    send_frame(8'h11, 1'b1);
    cyc(7);
    fork
      begin
        exp_q.push_back(8'h77);
        send_frame(8'h77, 1'b1);
      end
      begin
        cyc(LAT - 1);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
      end
    join
    chk("ack+commit data", rx_data, 8'h77);
    chk("ack+commit valid", rx_valid, 1);
    chk("ack+commit overrun", rx_overrun, 0);
    mdl_pending = 1;

    // Random bytes with random acknowledge
    for (int k = 0; k < 3; k++) begin
      if ($urandom_range(0, 1) == 1) ack_pulse();
      cyc($urandom_range(1, 40));
      rb = 8'($urandom);
      model_frame(rb);
      send_frame(rb, 1'b1);
      chk("random overrun", rx_overrun, mdl_ovr);
      chk("random valid", rx_valid, mdl_pending);
    end
    if (mdl_pending) ack_pulse();
    cyc(10);
    chk("scoreboard drained", exp_q.size(), 0);
    chk("total frame errs", fe_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
